// File: rtl/jt5205_multi.sv
// jt5205_multi: time-multiplexed multi-channel MSM5205-style ADPCM decoder.
// Each channel owns a tick divider, a 2-deep nibble FIFO and its decode state.
// One shared FSM/datapath (IDLE, FETCH, CALC, WB) decodes channels in turn,
// and a mixer sums all channel outputs into a single signed sample.
// Optional build macro: JT5205_MULTI_SAT_EN clamps the mixed output to 12 bits.

module jt5205_multi_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [1:0]  sel,
  input  logic [3:0]  din,
  input  logic        wr,
  input  logic        ch_rst,
  input  logic        pop,
  input  logic        urun_set,
  input  logic        pend_clr,
  input  logic        we,
  input  logic [11:0] sig_nxt,
  input  logic [5:0]  idx_nxt,
  output logic        pending,
  output logic        empty,
  output logic [3:0]  head,
  output logic        underrun,
  output logic [11:0] sig,
  output logic [5:0]  idx
);
  logic [6:0]      div;
  logic [6:0]      lim;
  logic            tick;
  logic [1:0][3:0] fifo;
  logic [1:0]      occ;
  logic            push;
  logic            wptr;

  // last divider count before a tick, per rate select
  always_comb begin
    lim = 7'd0;
    case (sel)
      2'd0:    lim = 7'd95;
      2'd1:    lim = 7'd63;
      2'd2:    lim = 7'd47;
      default: lim = 7'd0;
    endcase
  end

  assign tick  = cen && (sel != 2'd3) && (div >= lim);
  // a full FIFO still accepts a write when the head is popped the same clk
  assign push  = wr && ((occ != 2'd2) || pop);
  assign empty = (occ == 2'd0);
  assign head  = fifo[0];

  // write slot accounts for a same-cycle pop shifting the queue
  always_comb begin
    wptr = pop ? (occ == 2'd2) : occ[0];
  end

  // cen pulse divider; sel=3 parks the counter at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    div <= '0;
    else if (ch_rst || sel == 2'd3) div <= '0;
    else if (cen)                  div <= tick ? 7'd0 : div + 7'd1;
  end

  // pending request; a tick while already pending is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pending <= 1'b0;
    else if (ch_rst)   pending <= 1'b0;
    else if (pend_clr) pending <= 1'b0;
    else if (tick)     pending <= 1'b1;
  end

  // sticky underrun, cleared by any host write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        underrun <= 1'b0;
    else if (ch_rst)   underrun <= 1'b0;
    else if (urun_set) underrun <= 1'b1;
    else if (wr)       underrun <= 1'b0;
  end

  // two-entry nibble FIFO, head always in slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      fifo <= '0;
    end else if (ch_rst) begin
      occ  <= '0;
    end else begin
      if (pop)  fifo[0]    <= fifo[1];
      if (push) fifo[wptr] <= din;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // decoder state, committed only by the shared datapath write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
      idx <= '0;
    end else if (ch_rst) begin
      sig <= '0;
      idx <= '0;
    end else if (we) begin
      sig <= sig_nxt;
      idx <= idx_nxt;
    end
  end
endmodule

module jt5205_multi #(
  parameter int CH = 2,
  parameter int MW = 12 + $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic [2*CH-1:0]      sel,
  input  logic [4*CH-1:0]      din,
  input  logic [CH-1:0]        wr,
  input  logic [CH-1:0]        ch_rst,
  output logic [CH-1:0]        req,
  output logic [CH-1:0]        underrun,
  output logic [12*CH-1:0]     chan,
  output logic signed [MW-1:0] sound,
  output logic                 sample
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = 16;

  typedef enum logic [1:0] {IDLE, FETCH, CALC, WB} state_t;
  state_t st, st_nxt;

  logic [CW-1:0]         cur, pick;
  logic                  any_pend, abort, cur_rst, wb_fire;
  logic [3:0]            nib;
  logic signed [12:0]    dlt;
  logic [CH-1:0]         pend_a, empty_a, urun_a, pop_a, uset_a, pclr_a, we_a;
  logic [CH-1:0][3:0]    head_a;
  logic [CH-1:0][11:0]   sig_a;
  logic [CH-1:0][5:0]    idx_a;
  logic [11:0]           sig_nxt;
  logic [5:0]            idx_nxt;
  logic signed [13:0]    sum14;
  logic signed [7:0]     idx_sum;
  logic signed [AW-1:0]  mix, mix_o;
  logic [1:0]            vld_pipe;

  function automatic logic [10:0] step_of(input logic [5:0] i);
    case (i)
      6'd0: return 11'd16;    6'd1: return 11'd17;    6'd2: return 11'd19;    6'd3: return 11'd21;
      6'd4: return 11'd23;    6'd5: return 11'd25;    6'd6: return 11'd28;    6'd7: return 11'd31;
      6'd8: return 11'd34;    6'd9: return 11'd37;    6'd10: return 11'd41;   6'd11: return 11'd45;
      6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;   6'd15: return 11'd66;
      6'd16: return 11'd73;   6'd17: return 11'd80;   6'd18: return 11'd88;   6'd19: return 11'd97;
      6'd20: return 11'd107;  6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
      6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;  6'd27: return 11'd209;
      6'd28: return 11'd230;  6'd29: return 11'd253;  6'd30: return 11'd279;  6'd31: return 11'd307;
      6'd32: return 11'd337;  6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
      6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;  6'd39: return 11'd658;
      6'd40: return 11'd724;  6'd41: return 11'd796;  6'd42: return 11'd876;  6'd43: return 11'd963;
      6'd44: return 11'd1060; 6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
      default: return 11'd1552;
    endcase
  endfunction

  function automatic logic signed [7:0] adj_of(input logic [2:0] b);
    case (b)
      3'd4:    return 8'sd2;
      3'd5:    return 8'sd4;
      3'd6:    return 8'sd6;
      3'd7:    return 8'sd8;
      default: return -8'sd1;
    endcase
  endfunction

  // magnitude is at most 2910, so 13 signed bits hold either sign
  function automatic logic signed [12:0] delta_of(input logic [3:0] n, input logic [10:0] s);
    logic [12:0] d;
    d = {5'd0, s[10:3]};
    if (n[0]) d = d + {4'd0, s[10:2]};
    if (n[1]) d = d + {3'd0, s[10:1]};
    if (n[2]) d = d + {2'd0, s};
    return n[3] ? -$signed(d) : $signed(d);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      jt5205_multi_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .sel      (sel[2*gi +: 2]),
        .din      (din[4*gi +: 4]),
        .wr       (wr[gi]),
        .ch_rst   (ch_rst[gi]),
        .pop      (pop_a[gi]),
        .urun_set (uset_a[gi]),
        .pend_clr (pclr_a[gi]),
        .we       (we_a[gi]),
        .sig_nxt  (sig_nxt),
        .idx_nxt  (idx_nxt),
        .pending  (pend_a[gi]),
        .empty    (empty_a[gi]),
        .head     (head_a[gi]),
        .underrun (urun_a[gi]),
        .sig      (sig_a[gi]),
        .idx      (idx_a[gi])
      );
    end
  endgenerate

  assign cur_rst  = ch_rst[cur];
  assign req      = we_a;
  assign underrun = urun_a;
  assign chan     = sig_a;
  assign sample   = vld_pipe[1];

  // fixed priority: lowest pending channel index wins
  always_comb begin
    pick     = '0;
    any_pend = |pend_a;
    for (int i = CH - 1; i >= 0; i--)
      if (pend_a[i]) pick = CW'(i);
  end

  // FSM next state and per-channel control strobes
  always_comb begin
    st_nxt  = st;
    pop_a   = '0;
    uset_a  = '0;
    pclr_a  = '0;
    we_a    = '0;
    wb_fire = 1'b0;
    case (st)
      IDLE:  if (any_pend) st_nxt = FETCH;
      FETCH: begin
        st_nxt = IDLE;
        if (!cur_rst) begin
          if (empty_a[cur]) begin
            uset_a[cur] = 1'b1;
            pclr_a[cur] = 1'b1;
          end else begin
            pop_a[cur] = 1'b1;
            st_nxt     = CALC;
          end
        end
      end
      CALC:  st_nxt = WB;
      WB: begin
        st_nxt = IDLE;
        // a soft reset anywhere in CALC/WB throws the result away
        if (!abort && !cur_rst) begin
          wb_fire     = 1'b1;
          we_a[cur]   = 1'b1;
          pclr_a[cur] = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // FSM state and shared datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cur   <= '0;
      nib   <= '0;
      dlt   <= '0;
      abort <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == IDLE) begin
        cur   <= pick;
        abort <= 1'b0;
      end
      if (st == FETCH) nib <= head_a[cur];
      if (st == CALC)  dlt <= delta_of(nib, step_of(idx_a[cur]));
      if (st != IDLE && cur_rst) abort <= 1'b1;
    end
  end

  // write-back values: saturating signal and clamped step index
  always_comb begin
    sum14   = {{2{sig_a[cur][11]}}, sig_a[cur]} + {dlt[12], dlt};
    if (sum14 > 14'sd2047)       sig_nxt = 12'h7ff;
    else if (sum14 < -14'sd2048) sig_nxt = 12'h800;
    else                         sig_nxt = sum14[11:0];
    idx_sum = $signed({2'b00, idx_a[cur]}) + adj_of(nib[2:0]);
    if (idx_sum < 8'sd0)       idx_nxt = 6'd0;
    else if (idx_sum > 8'sd48) idx_nxt = 6'd48;
    else                       idx_nxt = idx_sum[5:0];
  end

  // mixer sum over all channels
  always_comb begin
    mix = '0;
    for (int i = 0; i < CH; i++)
      mix = mix + {{(AW-12){sig_a[i][11]}}, sig_a[i]};
`ifdef JT5205_MULTI_SAT_EN
    if (mix > 16'sd2047)       mix_o = 16'sd2047;
    else if (mix < -16'sd2048) mix_o = -16'sd2048;
    else                       mix_o = mix;
`else
    mix_o = mix;
`endif
  end

  // sound register follows a write-back by one clk; sample marks the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sound    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], wb_fire};
      if (vld_pipe[0]) sound <= MW'(mix_o);
    end
  end
endmodule

// File: tb/tb_jt5205_multi.sv
// Scoreboard bench for jt5205_multi (CH=4): a spec-level model predicts each
// decoded sample at cen time; a monitor pops and checks on every req/sample.
module tb_jt5205_multi;
  localparam int CH = 4;
  localparam int MW = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cen = 1'b0;
  logic [2*CH-1:0]   sel;
  logic [4*CH-1:0]   din;
  logic [CH-1:0]     wr, ch_rst, req, underrun;
  logic [12*CH-1:0]  chan;
  logic signed [MW-1:0] sound;
  logic              sample;

  jt5205_multi #(.CH(CH), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .din(din), .wr(wr),
    .ch_rst(ch_rst), .req(req), .underrun(underrun), .chan(chan),
    .sound(sound), .sample(sample)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, cen_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; int val; } exp_t;
  exp_t exp_q[$];
  int   m_sig[CH], m_idx[CH], m_cnt[CH], shadow[CH], last_req[CH];
  bit   m_urun[CH];
  int   m_fifo[CH][$];
  int   step_tab[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                         107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,
                         494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
  int   adj_tab[8] = '{-1,-1,-1,-1,2,4,6,8};
  bit   chk_v = 0;
  int   chk_ch, chk_val;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chanv(input int k);
    return int'($signed(chan[12*k +: 12]));
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int exp_sound();
    int s = 0;
    for (int i = 0; i < CH; i++) s += shadow[i];
`ifdef JT5205_MULTI_SAT_EN
    s = clampi(s, -2048, 2047);
`endif
    return s;
  endfunction

  // one cen pulse: every channel whose period elapses decodes its next nibble
  function automatic void model_cen();
    for (int i = 0; i < CH; i++) begin
      int per, st, d, n;
      exp_t e;
      case (sel[2*i +: 2])
        2'd0: per = 96;
        2'd1: per = 64;
        2'd2: per = 48;
        default: per = 0;
      endcase
      if (per == 0) continue;
      m_cnt[i]++;
      if (m_cnt[i] < per) continue;
      m_cnt[i] = 0;
      if (m_fifo[i].size() == 0) begin
        m_urun[i] = 1;
        continue;
      end
      n  = m_fifo[i].pop_front();
      st = step_tab[m_idx[i]];
      d  = st / 8;
      if (n & 1) d += st / 4;
      if (n & 2) d += st / 2;
      if (n & 4) d += st;
      if (n & 8) d = -d;
      m_sig[i] = clampi(m_sig[i] + d, -2048, 2047);
      m_idx[i] = clampi(m_idx[i] + adj_tab[n & 7], 0, 48);
      e.ch = i; e.val = m_sig[i];
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_wr(input logic [CH-1:0] m, input logic [4*CH-1:0] d);
    for (int i = 0; i < CH; i++)
      if (m[i]) begin
        if (m_fifo[i].size() < 2) m_fifo[i].push_back(int'(d[4*i +: 4]));
        m_urun[i] = 0;
      end
  endfunction

  function automatic void model_reset(input logic [CH-1:0] m);
    for (int i = 0; i < CH; i++)
      if (m[i]) begin
        m_sig[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_urun[i] = 0;
        shadow[i] = 0; m_fifo[i].delete();
      end
  endfunction

  // monitor: pops one expectation per req, checks chan a clk later and sound on sample
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_v) begin
        check("chan_update", chanv(chk_ch), chk_val);
        shadow[chk_ch] = chk_val;
        chk_v = 0;
      end
      for (int i = 0; i < CH; i++)
        if (req[i]) begin
          last_req[i] = cyc;
          if (exp_q.size() == 0) check("req_unexpected_ch", i, -1);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            check("req_channel", i, e.ch);
            chk_v = 1; chk_ch = i; chk_val = e.val;
          end
        end
      if (sample) check("sound", int'(sound), exp_sound());
    end
  end

  task automatic cen_slot(input logic [CH-1:0] m, input logic [4*CH-1:0] d);
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0; cen_cyc = cyc;
    model_cen();
    repeat (17) @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) check("underrun", int'(underrun[i]), int'(m_urun[i]));
    din = d; wr = m;
    @(posedge clk); #1;
    wr = '0;
    model_wr(m, d);
    @(posedge clk); #1;
  endtask

  task automatic ch_rst_pulse(input logic [CH-1:0] m);
    ch_rst = m;
    @(posedge clk); #1;
    ch_rst = '0;
    model_reset(m);
  endtask

  initial begin
    sel = {2'd3, 2'd1, 2'd0, 2'd2};
    din = '0; wr = '0; ch_rst = '0;
    model_reset('1);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) check("rst_chan", chanv(i), 0);
    check("rst_sound", int'(sound), 0);
    check("rst_req", int'(req), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_sample", int'(sample), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // rates 48/96/64/off; ch0 gets 0x0 then a stream of 0x7, others random
    for (int s = 0; s < 1200; s++) begin
      logic [CH-1:0]   m;
      logic [4*CH-1:0] d;
      d = 16'($urandom);
      m[0] = 1'b1;
      d[3:0] = (s == 0) ? 4'h0 : 4'h7;
      m[1] = ($urandom_range(0, 149) == 0);
      m[2] = ($urandom_range(0, 39) == 0);
      m[3] = ($urandom_range(0, 9) == 0);
      cen_slot(m, d);
    end
    check("ch0_saturated", chanv(0), 2047);

    // contention: all channels tick on the same cen
    sel = 8'hAA;
    ch_rst_pulse('1);
    for (int s = 0; s < 48; s++) cen_slot('1, 16'($urandom));
    for (int i = 0; i < CH; i++) check("service_slot", last_req[i] - cen_cyc, 3 + 4*i);

    // soft reset of ch1 while its nibble is in CALC
    sel = 8'hFB;
    ch_rst_pulse('1);
    for (int s = 0; s < 47; s++) cen_slot((s < 2) ? 4'b0010 : 4'b0000, 16'($urandom));
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    model_cen();
    @(posedge clk); #1;
    @(posedge clk); #1;
    ch_rst = 4'b0010;
    @(posedge clk); #1;
    ch_rst = '0;
    if (exp_q.size() > 0) exp_q.pop_back();
    model_reset(4'b0010);
    repeat (16) @(posedge clk);
    #1;
    check("softrst_chan1", chanv(1), 0);
    for (int s = 0; s < 48; s++) cen_slot('0, '0);
    check("softrst_fifo_empty", int'(underrun[1]), 1);

    // two channels driven to full scale for the mixer
    sel = 8'hFA;
    ch_rst_pulse('1);
    for (int s = 0; s < 480; s++) cen_slot(4'b0011, 16'h0077);
`ifdef JT5205_MULTI_SAT_EN
    check("mix_full_scale", int'(sound), 2047);
`else
    check("mix_full_scale", int'(sound), 4094);
`endif

    // asynchronous reset in the middle of a decode
    for (int s = 0; s < 47; s++) cen_slot(4'b0011, 16'h0011);
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < CH; i++) check("arst_chan", chanv(i), 0);
    check("arst_sound", int'(sound), 0);
    check("arst_req", int'(req), 0);
    check("arst_sample", int'(sample), 0);
    check("arst_underrun", int'(underrun), 0);
    exp_q.delete();
    chk_v = 0;
    model_reset('1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
